// File: rtl/zmem_arbiter_if.sv
// Requester and RAM-side signals of the shared RAM port arbiter.
// slave  : arbiter view (requests and mem_rdata in; handshakes and RAM cycle out)
// master : environment view (requesters plus RAM model)
interface zmem_arbiter_if;
    logic        vid_req;
    logic [21:0] vid_addr;
    logic        cpu_req;
    logic        cpu_rnw;
    logic [21:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        dma_req;
    logic        dma_rnw;
    logic [21:0] dma_addr;
    logic [7:0]  dma_wdata;
    logic        vid_next;
    logic        cpu_next;
    logic        dma_next;
    logic        vid_strobe;
    logic        cpu_strobe;
    logic        dma_strobe;
    logic [7:0]  rdata;
    logic        mem_req;
    logic        mem_rnw;
    logic [21:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    modport slave (
        input  vid_req, vid_addr,
        input  cpu_req, cpu_rnw, cpu_addr, cpu_wdata,
        input  dma_req, dma_rnw, dma_addr, dma_wdata,
        input  mem_rdata,
        output vid_next, cpu_next, dma_next,
        output vid_strobe, cpu_strobe, dma_strobe,
        output rdata,
        output mem_req, mem_rnw, mem_addr, mem_wdata
    );

    modport master (
        output vid_req, vid_addr,
        output cpu_req, cpu_rnw, cpu_addr, cpu_wdata,
        output dma_req, dma_rnw, dma_addr, dma_wdata,
        output mem_rdata,
        input  vid_next, cpu_next, dma_next,
        input  vid_strobe, cpu_strobe, dma_strobe,
        input  rdata,
        input  mem_req, mem_rnw, mem_addr, mem_wdata
    );
endinterface

// File: rtl/zmem_arbiter.sv
// Shares the external 4 MB RAM port between video fetch, Z80 and DMA.
// Fixed-length RAM cycles; video has priority but is limited to VID_BURST
// consecutive grants while cpu/dma wait; cpu and dma alternate round-robin.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no RAM cycle; every edge is an arbitrate point
// BUSY  | RAM cycle in progress, cnt 0..CYCLE_LEN-1; last count arbitrates
module zmem_arbiter #(
    parameter int CYCLE_LEN = 4,
    parameter int VID_BURST = 3
) (
    input  logic           fclk,
    input  logic           rst,
    zmem_arbiter_if.slave  bus
);

    localparam int RUN_W = (VID_BURST < 1) ? 1 : $clog2(VID_BURST + 1);
    localparam logic [3:0]       CNT_LAST = 4'(CYCLE_LEN - 1);
    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(VID_BURST);

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_VID,
        OWN_CPU,
        OWN_DMA
    } owner_t;

    state_t           state_q, state_d;
    owner_t           owner_q, win;
    logic [3:0]       cnt_q;
    logic [RUN_W-1:0] vid_run_q;
    logic             rr_q;          // 0: cpu preferred, 1: dma preferred
    logic             cyc_end;
    logic             arb;
    logic             vid_blocked;

    // state register
    always_ff @(posedge fclk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // arbitration and next state
    always_comb begin
        cyc_end     = (state_q == ST_BUSY) && (cnt_q == CNT_LAST);
        arb         = (state_q == ST_IDLE) || cyc_end;
        vid_blocked = (vid_run_q == RUN_MAX) && (bus.cpu_req || bus.dma_req);
        win         = OWN_NONE;
        state_d     = state_q;
        if (arb) begin
            if (bus.vid_req && !vid_blocked)     win = OWN_VID;
            else if (bus.cpu_req && bus.dma_req) win = rr_q ? OWN_DMA : OWN_CPU;
            else if (bus.cpu_req)                win = OWN_CPU;
            else if (bus.dma_req)                win = OWN_DMA;
            state_d = (win != OWN_NONE) ? ST_BUSY : ST_IDLE;
        end
    end

    // RAM cycle sequencing, handshake pulses and read data capture
    always_ff @(posedge fclk) begin
        if (rst) begin
            cnt_q          <= '0;
            vid_run_q      <= '0;
            rr_q           <= 1'b0;
            owner_q        <= OWN_NONE;
            bus.vid_next   <= 1'b0;
            bus.cpu_next   <= 1'b0;
            bus.dma_next   <= 1'b0;
            bus.vid_strobe <= 1'b0;
            bus.cpu_strobe <= 1'b0;
            bus.dma_strobe <= 1'b0;
            bus.rdata      <= '0;
            bus.mem_req    <= 1'b0;
            bus.mem_rnw    <= 1'b0;
            bus.mem_addr   <= '0;
            bus.mem_wdata  <= '0;
        end else begin
            bus.vid_next   <= 1'b0;
            bus.cpu_next   <= 1'b0;
            bus.dma_next   <= 1'b0;
            bus.vid_strobe <= 1'b0;
            bus.cpu_strobe <= 1'b0;
            bus.dma_strobe <= 1'b0;

            if (state_q == ST_BUSY && !cyc_end)
                cnt_q <= cnt_q + 4'd1;

            if (cyc_end) begin
                case (owner_q)
                    OWN_VID: bus.vid_strobe <= 1'b1;
                    OWN_CPU: bus.cpu_strobe <= 1'b1;
                    OWN_DMA: bus.dma_strobe <= 1'b1;
                    default: ;
                endcase
                if (bus.mem_rnw)  bus.rdata <= bus.mem_rdata;
                if (!bus.vid_req) vid_run_q <= '0;
            end

            if (arb) begin
                owner_q <= win;
                case (win)
                    OWN_VID: begin
                        bus.mem_req  <= 1'b1;
                        bus.mem_rnw  <= 1'b1;
                        bus.mem_addr <= bus.vid_addr;
                        bus.vid_next <= 1'b1;
                        cnt_q        <= '0;
                        if (vid_run_q != RUN_MAX) vid_run_q <= vid_run_q + 1'b1;
                    end
                    OWN_CPU: begin
                        bus.mem_req   <= 1'b1;
                        bus.mem_rnw   <= bus.cpu_rnw;
                        bus.mem_addr  <= bus.cpu_addr;
                        bus.mem_wdata <= bus.cpu_wdata;
                        bus.cpu_next  <= 1'b1;
                        cnt_q         <= '0;
                        rr_q          <= 1'b1;
                        vid_run_q     <= '0;
                    end
                    OWN_DMA: begin
                        bus.mem_req   <= 1'b1;
                        bus.mem_rnw   <= bus.dma_rnw;
                        bus.mem_addr  <= bus.dma_addr;
                        bus.mem_wdata <= bus.dma_wdata;
                        bus.dma_next  <= 1'b1;
                        cnt_q         <= '0;
                        rr_q          <= 1'b0;
                        vid_run_q     <= '0;
                    end
                    default: begin
                        bus.mem_req <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_zmem_arbiter.sv
// Directed bench for zmem_arbiter (CYCLE_LEN=4, VID_BURST=3).
module tb_zmem_arbiter;

    logic fclk;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    zmem_arbiter_if bus ();

    zmem_arbiter #(.CYCLE_LEN(4), .VID_BURST(3)) dut (
        .fclk (fclk),
        .rst  (rst),
        .bus  (bus)
    );

    initial fclk = 1'b0;
    always #5 fclk = ~fclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge fclk);
        #1;
    endtask

    // wait (bounded) for the next grant; who: 0 vid, 1 cpu, 2 dma, -1 timeout
    task automatic wait_next(output int who);
        who = -1;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (bus.vid_next || bus.cpu_next || bus.dma_next) begin
                check("one_next", 32'($countones({bus.vid_next, bus.cpu_next, bus.dma_next})), 1);
                who = bus.vid_next ? 0 : (bus.cpu_next ? 1 : 2);
                return;
            end
        end
        check("next_timeout", 32'(who), 0);
    endtask

    // remaining clocks of a cycle just granted: 3 busy clocks, then strobe
    task automatic serve_tail(input string tag, input logic [2:0] exp_strobe, input logic exp_req);
        for (int i = 0; i < 3; i++) begin
            cyc();
            check({tag, "_busy"}, {bus.mem_req, bus.vid_strobe, bus.cpu_strobe, bus.dma_strobe}, 4'b1000);
        end
        cyc();
        check({tag, "_strobe"}, {bus.vid_strobe, bus.cpu_strobe, bus.dma_strobe}, exp_strobe);
        check({tag, "_req_end"}, bus.mem_req, exp_req);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int who;
        int exp4 [4];
        int exp5 [8];
        exp4 = '{1, 2, 1, 2};
        exp5 = '{0, 0, 0, 1, 0, 0, 0, 1};

        rst           = 1'b1;
        bus.vid_req   = 1'b1;  bus.vid_addr  = 22'h00_0ABC;
        bus.cpu_req   = 1'b1;  bus.cpu_rnw   = 1'b1;  bus.cpu_addr = 22'h01_0000;  bus.cpu_wdata = 8'h00;
        bus.dma_req   = 1'b1;  bus.dma_rnw   = 1'b1;  bus.dma_addr = 22'h02_0000;  bus.dma_wdata = 8'h00;
        bus.mem_rdata = 8'h5C;

        // 1: reset with all requests high
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("t1_rst_outs", {bus.mem_req, bus.vid_next, bus.cpu_next, bus.dma_next,
                                  bus.vid_strobe, bus.cpu_strobe, bus.dma_strobe}, 7'b0);
            check("t1_rst_data", {bus.rdata, bus.mem_addr}, 30'b0);
        end
        rst = 1'b0;
        cyc();
        check("t1_first_vid", {bus.vid_next, bus.cpu_next, bus.dma_next}, 3'b100);
        check("t1_addr", bus.mem_addr, 22'h00_0ABC);
        bus.vid_req = 1'b0;  bus.cpu_req = 1'b0;  bus.dma_req = 1'b0;
        serve_tail("t1", 3'b100, 1'b0);
        check("t1_rdata", bus.rdata, 8'h5C);

        // 2: single cpu read from IDLE
        cyc();
        bus.cpu_req = 1'b1;  bus.cpu_rnw = 1'b1;  bus.cpu_addr = 22'h15_3FFF;
        bus.mem_rdata = 8'hA5;
        cyc();
        check("t2_next", {bus.vid_next, bus.cpu_next, bus.dma_next}, 3'b010);
        check("t2_mem", {bus.mem_req, bus.mem_rnw, bus.mem_addr}, {2'b11, 22'h15_3FFF});
        bus.cpu_req = 1'b0;
        serve_tail("t2", 3'b010, 1'b0);
        check("t2_rdata", bus.rdata, 8'hA5);
        cyc();
        check("t2_hold", {bus.cpu_strobe, bus.rdata}, {1'b0, 8'hA5});

        // 3: vid and cpu together -> vid then cpu back-to-back
        bus.vid_req = 1'b1;  bus.vid_addr = 22'h00_1234;
        bus.cpu_req = 1'b1;  bus.cpu_rnw = 1'b1;  bus.cpu_addr = 22'h2A_0001;
        bus.mem_rdata = 8'h3C;
        cyc();
        check("t3_vid_next", {bus.vid_next, bus.cpu_next, bus.mem_addr}, {2'b10, 22'h00_1234});
        bus.vid_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("t3_busy", bus.mem_req, 1'b1);
        end
        cyc();
        check("t3_overlap", {bus.vid_strobe, bus.cpu_next, bus.mem_req}, 3'b111);
        check("t3_cpu_addr", bus.mem_addr, 22'h2A_0001);
        check("t3_vid_rdata", bus.rdata, 8'h3C);
        bus.cpu_req = 1'b0;
        bus.mem_rdata = 8'h5A;
        serve_tail("t3", 3'b010, 1'b0);
        check("t3_cpu_rdata", bus.rdata, 8'h5A);

        // 4: dma read sets rr back to cpu, then alternating writes
        bus.dma_req = 1'b1;  bus.dma_rnw = 1'b1;  bus.dma_addr = 22'h3F_FFFF;
        bus.mem_rdata = 8'h77;
        cyc();
        check("t4_dma_next", {bus.dma_next, bus.mem_addr}, {1'b1, 22'h3F_FFFF});
        bus.dma_req = 1'b0;
        serve_tail("t4r", 3'b001, 1'b0);
        check("t4_rdata_rd", bus.rdata, 8'h77);
        bus.cpu_req = 1'b1;  bus.cpu_rnw = 1'b0;  bus.cpu_addr = 22'h00_0010;  bus.cpu_wdata = 8'h11;
        bus.dma_req = 1'b1;  bus.dma_rnw = 1'b0;  bus.dma_addr = 22'h00_0020;  bus.dma_wdata = 8'h22;
        bus.mem_rdata = 8'hEE;
        for (int i = 0; i < 4; i++) begin
            wait_next(who);
            check("t4_who", 32'(who), 32'(exp4[i]));
            check("t4_wr", {bus.mem_rnw, bus.mem_wdata}, {1'b0, (i % 2 == 1) ? 8'h22 : 8'h11});
        end
        bus.cpu_req = 1'b0;  bus.dma_req = 1'b0;
        serve_tail("t4w", 3'b001, 1'b0);
        check("t4_rdata_kept", bus.rdata, 8'h77);

        // 5: video burst limit
        bus.vid_req = 1'b1;  bus.vid_addr = 22'h00_0100;
        bus.cpu_req = 1'b1;  bus.cpu_rnw = 1'b1;  bus.cpu_addr = 22'h00_0200;
        for (int i = 0; i < 8; i++) begin
            wait_next(who);
            check("t5_who", 32'(who), 32'(exp5[i]));
        end
        bus.vid_req = 1'b0;  bus.cpu_req = 1'b0;
        serve_tail("t5", 3'b010, 1'b0);

        // 6: reset during a dma read
        bus.dma_req = 1'b1;  bus.dma_rnw = 1'b1;  bus.dma_addr = 22'h12_3456;
        bus.mem_rdata = 8'h99;
        cyc();
        check("t6_dma_next", bus.dma_next, 1'b1);
        bus.dma_req = 1'b0;
        cyc();
        cyc();
        rst = 1'b1;
        cyc();
        check("t6_rst_outs", {bus.mem_req, bus.dma_strobe, bus.mem_addr}, 24'b0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("t6_no_strobe", {bus.mem_req, bus.vid_strobe, bus.cpu_strobe, bus.dma_strobe}, 4'b0);
        end
        check("t6_rdata_clr", bus.rdata, 8'h00);
        bus.cpu_req = 1'b1;  bus.cpu_rnw = 1'b1;  bus.cpu_addr = 22'h00_0042;
        bus.mem_rdata = 8'h42;
        cyc();
        check("t6_restart", {bus.cpu_next, bus.mem_req, bus.mem_addr}, {2'b11, 22'h00_0042});
        bus.cpu_req = 1'b0;
        serve_tail("t6", 3'b010, 1'b0);
        check("t6_rdata", bus.rdata, 8'h42);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
